// File: rtl/hall98_sequencer_if.sv
// Instruction-memory fetch bus for hall98_sequencer.
// The sequencer drives req/addr. The memory returns ack/rdata, and ack may come in the first req cycle.
interface hall98_sequencer_if #(
  parameter int unsigned PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/hall98_sequencer.sv
// hall98 instruction fetch/issue controller.
// Fetches 32-bit words over a req/ack bus and decodes each word.
// An ALU op is presented to the core for exactly one cycle.
// NOP, HALT and illegal words are consumed without an issue.
// Optional feature: define HALL98_SEQ_JMP_EN to make op 0x4B an unconditional jump.
// When the macro is undefined, 0x4B is illegal.
module hall98_sequencer #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned ISSUE_GAP = 0
) (
  input  logic                 iclock,
  input  logic                 irst_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 stop,
  hall98_sequencer_if.master   imem,
  output logic [31:0]          opcode,
  output logic [31:0]          re,
  output logic [31:0]          n,
  output logic                 flag,
  output logic                 issue,
  output logic [PC_W-1:0]      pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [31:0]          icount
);

`ifdef HALL98_SEQ_JMP_EN
  localparam bit JmpEn = 1'b1;
`else
  localparam bit JmpEn = 1'b0;
`endif

  // GAP counts down from ISSUE_GAP-1 to 0. With ISSUE_GAP = 0, the GAP state is never entered.
  localparam logic [3:0] GapInit = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StGap, StHalted} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     icount_q, icount_d;
  logic            err_q, err_d;
  logic            stop_pend_q, stop_pend_d;
  logic [3:0]      gap_q, gap_d;
  logic [7:0]      op_q, op_d;
  logic            flag_q, flag_d;
  logic [2:0]      re_q, re_d;
  logic [19:0]     n_q, n_d;

  logic [7:0] rd_op;
  logic       is_alu, is_nop, is_halt, is_jmp, stop_now;

  // Decode the word currently on the read-data bus.
  always_comb begin
    rd_op   = imem.imem_rdata[31:24];
    is_alu  = (rd_op >= 8'h45) && (rd_op <= 8'h4A);
    is_nop  = (rd_op == 8'h00);
    is_halt = (rd_op == 8'hFF);
    is_jmp  = JmpEn && (rd_op == 8'h4B);
    // A stop arriving in the same cycle as the boundary decision still takes effect.
    stop_now = stop_pend_q | stop;
  end

  // Compute next-state and outputs. Every core field stays 0 outside ISSUE.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    icount_d       = icount_q;
    err_d          = err_q;
    stop_pend_d    = stop_pend_q;
    gap_d          = gap_q;
    op_d           = op_q;
    flag_d         = flag_q;
    re_d           = re_q;
    n_d            = n_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;
    opcode         = '0;
    re             = '0;
    n              = '0;
    flag           = 1'b0;
    issue          = 1'b0;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          pc_d        = start_pc;
          err_d       = 1'b0;
          stop_pend_d = stop;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_q;
        if (stop) stop_pend_d = 1'b1;
        if (imem.imem_ack) begin
          if (is_alu) begin
            op_d    = rd_op;
            flag_d  = imem.imem_rdata[23];
            re_d    = imem.imem_rdata[22:20];
            n_d     = imem.imem_rdata[19:0];
            state_d = StIssue;
          end else if (is_nop) begin
            pc_d = pc_q + PC_W'(1);
            if (stop_now) state_d = StHalted;
          end else if (is_halt) begin
            state_d = StHalted;
          end else if (is_jmp) begin
            pc_d = PC_W'(imem.imem_rdata[19:0]);
            if (stop_now) state_d = StHalted;
          end else begin
            // Illegal op: pc keeps the offending address.
            err_d   = 1'b1;
            state_d = StHalted;
          end
        end
      end
      StIssue: begin
        issue    = 1'b1;
        opcode   = {24'd0, op_q};
        re       = {29'd0, re_q};
        n        = {12'd0, n_q};
        flag     = flag_q;
        pc_d     = pc_q + PC_W'(1);
        icount_d = (icount_q != 32'hFFFF_FFFF) ? icount_q + 32'd1 : icount_q;
        if (stop) stop_pend_d = 1'b1;
        if (ISSUE_GAP > 0) begin
          gap_d   = GapInit;
          state_d = StGap;
        end else if (stop_now) begin
          state_d = StHalted;
        end else begin
          state_d = StFetch;
        end
      end
      StGap: begin
        if (stop) stop_pend_d = 1'b1;
        if (gap_q == 4'd0) begin
          state_d = stop_now ? StHalted : StFetch;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register the state. Reset returns to IDLE immediately, so every output goes to 0.
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      icount_q    <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      gap_q       <= '0;
      op_q        <= '0;
      flag_q      <= 1'b0;
      re_q        <= '0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      icount_q    <= icount_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      gap_q       <= gap_d;
      op_q        <= op_d;
      flag_q      <= flag_d;
      re_q        <= re_d;
      n_q         <= n_d;
    end
  end

  // Drive the status outputs.
  always_comb begin
    pc     = pc_q;
    icount = icount_q;
    err    = err_q;
    busy   = (state_q == StFetch) || (state_q == StIssue) || (state_q == StGap);
    halted = (state_q == StHalted);
  end

endmodule

// File: tb/tb_hall98_sequencer.sv
// Directed bench for hall98_sequencer (PC_W = 16, ISSUE_GAP = 0).
// A decode table is followed by hand-written multi-cycle sequences.
module tb_hall98_sequencer;
  localparam int unsigned PC_W = 16;
  localparam logic [31:0] HaltW = 32'hFF00_0000;

  logic            iclock = 1'b0;
  logic            irst_n = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] start_pc = '0;
  logic            stop = 1'b0;
  logic [31:0]     opcode, re, n, icount;
  logic            flag, issue, busy, halted, err;
  logic [PC_W-1:0] pc;

  hall98_sequencer_if #(.PC_W(PC_W)) imem_bus ();

  hall98_sequencer #(.PC_W(PC_W), .ISSUE_GAP(0)) dut (
    .iclock   (iclock),
    .irst_n   (irst_n),
    .start    (start),
    .start_pc (start_pc),
    .stop     (stop),
    .imem     (imem_bus.master),
    .opcode   (opcode),
    .re       (re),
    .n        (n),
    .flag     (flag),
    .issue    (issue),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
    .err      (err),
    .icount   (icount)
  );

  always #5 iclock = ~iclock;

  // The memory model acks after ack_delay wait cycles; zero gives an ack in the first req cycle.
  logic [31:0] mem [0:65535];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt == ack_delay);
  assign imem_bus.imem_rdata = mem[imem_bus.imem_addr];

  always @(posedge iclock) begin
    if (imem_bus.imem_req && !imem_bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int unsigned cyc = 0;
  always @(posedge iclock) cyc <= cyc + 1;

  // Record every issue and watch that the address stays stable while a request is pending.
  typedef struct {
    int unsigned cyc;
    logic [31:0] op;
    logic [31:0] re;
    logic [31:0] n;
    logic        flag;
  } iss_t;
  iss_t        issues[$];
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;
  int          addr_err = 0;

  always @(negedge iclock) begin
    if (issue) issues.push_back('{cyc: cyc, op: opcode, re: re, n: n, flag: flag});
    if (imem_bus.imem_req && prev_req && !prev_ack && imem_bus.imem_addr != prev_addr)
      addr_err <= addr_err + 1;
    prev_req  <= imem_bus.imem_req;
    prev_ack  <= imem_bus.imem_ack;
    prev_addr <= imem_bus.imem_addr;
  end

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned t0 = 0;
  int unsigned halt_cyc = 0;
  logic [31:0] exp_icount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = HaltW;
  endtask

  // start is high for one cycle; that cycle is cycle 0 of the run.
  task automatic do_start(input logic [PC_W-1:0] spc, input logic stp);
    @(posedge iclock);
    #1;
    start    = 1'b1;
    start_pc = spc;
    stop     = stp;
    t0       = cyc;
    @(posedge iclock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_halted(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge iclock);
      if (halted) begin
        seen     = 1'b1;
        halt_cyc = cyc - t0;
      end
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] n_iss;
    logic [31:0] op;
    logic [31:0] re;
    logic [31:0] n;
    logic        flag;
    logic        err;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[$];

  initial begin
    // Word at address 0, then HALT at 1. Expected fields are hand-decoded.
    vecs.push_back('{32'h4510_0005, 1, 32'h45, 1, 32'h00005, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h46FF_FFFF, 1, 32'h46, 7, 32'hFFFFF, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h4721_2345, 1, 32'h47, 2, 32'h12345, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h4880_0000, 1, 32'h48, 0, 32'h00000, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h495A_BCDE, 1, 32'h49, 5, 32'hABCDE, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h4AB0_0001, 1, 32'h4A, 3, 32'h00001, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h0000_0000, 0, 0, 0, 0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hFF12_3456, 0, 0, 0, 0, 1'b0, 1'b0, 0});
    vecs.push_back('{32'h1200_0000, 0, 0, 0, 0, 1'b0, 1'b1, 0});
    vecs.push_back('{32'h4400_0000, 0, 0, 0, 0, 1'b0, 1'b1, 0});
    vecs.push_back('{32'h4C00_0000, 0, 0, 0, 0, 1'b0, 1'b1, 0});
`ifdef HALL98_SEQ_JMP_EN
    vecs.push_back('{32'h4B00_0010, 0, 0, 0, 0, 1'b0, 1'b0, 32'h10});
`else
    vecs.push_back('{32'h4B00_0010, 0, 0, 0, 0, 1'b0, 1'b1, 0});
`endif

    clear_mem();
    repeat (3) @(posedge iclock);
    @(negedge iclock);
    chk("rst_issue", {31'd0, issue}, 0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_pc", {16'd0, pc}, 0);
    chk("rst_icount", icount, 0);
    irst_n = 1'b1;

    // Basic program with zero-wait ack.
    mem[0] = 32'h4510_0005;
    mem[1] = 32'h4610_0001;
    mem[2] = HaltW;
    issues.delete();
    do_start(16'h0000, 1'b0);
    wait_halted(30);
    chk("basic_n_issue", issues.size(), 2);
    if (issues.size() >= 2) begin
      chk("basic_iss0_cyc", issues[0].cyc - t0, 2);
      chk("basic_iss1_cyc", issues[1].cyc - t0, 4);
      chk("basic_iss0_op", issues[0].op, 32'h45);
      chk("basic_iss1_op", issues[1].op, 32'h46);
    end
    chk("basic_halt_cyc", halt_cyc, 6);
    chk("basic_pc", {16'd0, pc}, 2);
    chk("basic_icount", icount, 2);
    chk("basic_err", {31'd0, err}, 0);
    chk("basic_opcode_idle", opcode, 0);

    // Three wait cycles per fetch: 5-cycle issue spacing and a stable address.
    ack_delay = 3;
    issues.delete();
    do_start(16'h0000, 1'b0);
    wait_halted(60);
    chk("slow_n_issue", issues.size(), 2);
    if (issues.size() >= 2) begin
      chk("slow_iss0_cyc", issues[0].cyc - t0, 5);
      chk("slow_spacing", issues[1].cyc - issues[0].cyc, 5);
    end
    chk("slow_addr_stable", addr_err, 0);
    chk("slow_icount", icount, 4);
    ack_delay = 0;

    // Illegal word at address 4; the next start clears err.
    mem[4] = 32'h1200_0000;
    issues.delete();
    do_start(16'h0004, 1'b0);
    wait_halted(20);
    chk("ill_err", {31'd0, err}, 1);
    chk("ill_pc", {16'd0, pc}, 4);
    chk("ill_n_issue", issues.size(), 0);
    chk("ill_icount", icount, 4);
    do_start(16'h0002, 1'b0);
    wait_halted(20);
    chk("ill_err_cleared", {31'd0, err}, 0);
    chk("ill_restart_pc", {16'd0, pc}, 2);

    // Stop while a fetch waits for its ack: that ALU op still issues, and then the core halts.
    clear_mem();
    mem[0] = 32'h4510_0005;
    mem[1] = 32'h4610_0001;
    mem[2] = 32'h4710_0001;
    mem[3] = 32'h4810_0001;
    ack_delay = 3;
    issues.delete();
    do_start(16'h0000, 1'b0);
    @(posedge iclock);
    #1 stop = 1'b1;
    @(posedge iclock);
    #1 stop = 1'b0;
    wait_halted(60);
    chk("stop_n_issue", issues.size(), 1);
    if (issues.size() >= 1) chk("stop_iss_op", issues[0].op, 32'h45);
    chk("stop_pc", {16'd0, pc}, 1);
    chk("stop_icount", icount, 5);
    chk("stop_halt_cyc", halt_cyc, 6);
    ack_delay = 0;

    // pc wraps: NOP at 0xFFFF, then ALU at 0x0000.
    clear_mem();
    mem[16'hFFFF] = 32'h0000_0000;
    mem[0]        = 32'h4721_2345;
    issues.delete();
    do_start(16'hFFFF, 1'b0);
    wait_halted(20);
    chk("wrap_n_issue", issues.size(), 1);
    if (issues.size() >= 1) chk("wrap_iss_op", issues[0].op, 32'h47);
    chk("wrap_pc", {16'd0, pc}, 1);
    chk("wrap_icount", icount, 6);

    // Asynchronous reset in the middle of ISSUE.
    mem[0] = 32'h4510_0005;
    mem[1] = 32'h4610_0001;
    do_start(16'h0000, 1'b0);
    @(posedge iclock);
    #1;
    chk("rstiss_pre_issue", {31'd0, issue}, 1);
    irst_n = 1'b0;
    #1;
    chk("rstiss_issue", {31'd0, issue}, 0);
    chk("rstiss_opcode", opcode, 0);
    chk("rstiss_req", {31'd0, imem_bus.imem_req}, 0);
    chk("rstiss_pc", {16'd0, pc}, 0);
    chk("rstiss_icount", icount, 0);
    start = 1'b1;
    @(posedge iclock);
    #1 start = 1'b0;
    @(posedge iclock);
    #1 irst_n = 1'b1;
    @(negedge iclock);
    chk("rstiss_busy_idle", {31'd0, busy}, 0);
    @(negedge iclock);
    chk("rstiss_halted_idle", {31'd0, halted}, 0);
    do_start(16'h0000, 1'b0);
    wait_halted(20);
    chk("rstiss_rerun_icount", icount, 2);
    exp_icount = 2;

    // Decode table: one word at address 0, then HALT.
    clear_mem();
    for (int i = 0; i < vecs.size(); i++) begin
      mem[0] = vecs[i].word;
      issues.delete();
      do_start(16'h0000, 1'b0);
      wait_halted(20);
      exp_icount = exp_icount + vecs[i].n_iss;
      chk($sformatf("vec%0d_n_issue", i), issues.size(), vecs[i].n_iss);
      if (issues.size() >= 1) begin
        chk($sformatf("vec%0d_op", i), issues[0].op, vecs[i].op);
        chk($sformatf("vec%0d_re", i), issues[0].re, vecs[i].re);
        chk($sformatf("vec%0d_n", i), issues[0].n, vecs[i].n);
        chk($sformatf("vec%0d_flag", i), {31'd0, issues[0].flag}, {31'd0, vecs[i].flag});
      end
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_pc", i), {16'd0, pc}, vecs[i].pc);
      chk($sformatf("vec%0d_icount", i), icount, exp_icount);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 0);
      mem[0] = HaltW;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Bound the whole run so that a stuck design still reaches the summary line.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hall98_sequencer.md
Name: hall98_sequencer

Overview:
- Instruction fetch/issue controller for the hall98 core.
- Fetches 32-bit instruction words from a program memory over a req/ack handshake and decodes them into the core's opcode/re/n/flag inputs.
- Presents each instruction for exactly one clock, then NOP (opcode 0) until the next issue.
- Handles start/stop, HALT, illegal-opcode detection and retired-instruction counting.

Parameters:
- PC_W, 16, program counter and instruction-memory address width.
- ISSUE_GAP, 0, idle cycles (opcode 0) inserted after every issue; range 0..15.

Ports:
- iclock  in  1  system clock, rising edge.
- irst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse, honoured in IDLE or HALTED.
- start_pc  in  PC_W  first fetch address, sampled with start.
- stop  in  1  request halt at next instruction boundary.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- opcode  out  32  to core; zero-extended op byte during issue, else 0.
- re  out  32  to core; zero-extended register select.
- n  out  32  to core; zero-extended immediate/address/register field.
- flag  out  1  to core; 0 except during issue.
- issue  out  1  high for the single cycle the core fields are valid.
- pc  out  PC_W  current program counter.
- busy  out  1  state is FETCH, ISSUE or GAP.
- halted  out  1  state is HALTED.
- err  out  1  illegal opcode seen; sticky until next start.
- icount  out  32  retired (issued) instruction count; saturates at 0xFFFFFFFF.

Behaviour:
- Instruction word fields:
  - [31:24] op.
  - [23] flag.
  - [22:20] re.
  - [19:0] n.
- Legal ops:
  - 0x45 mov, 0x46 add, 0x47 sub, 0x48 mul, 0x49 ldr, 0x4A str: issued to the core.
  - 0x00: NOP, consumed without issue.
  - 0xFF: HALT.
  - All others are illegal.
- Reset (asynchronous, any state): state IDLE; pc=0; icount=0; err=0; stop_pend=0. Every output 0 immediately, including imem_req.
- IDLE: on start, pc<=start_pc, go to FETCH. stop is ignored unless start is high in the same cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack. An ack in the first req cycle is legal.
  - On ack, decode imem_rdata:
    - Legal ALU op: latch fields, go to ISSUE.
    - NOP: pc<=pc+1, stay in FETCH, or go to HALTED if stop_pend.
    - HALT: go to HALTED; pc is not incremented.
    - Illegal: err<=1, go to HALTED; pc holds the offending address.
  - imem_req drops in the cycle after ack.
- ISSUE (1 cycle):
  - issue=1; opcode/re/n/flag driven from the latched fields.
  - pc<=pc+1, wrapping modulo 2^PC_W; icount<=icount+1, saturating.
  - Next state: GAP if ISSUE_GAP>0; else HALTED if stop_pend; else FETCH.
- GAP: ISSUE_GAP cycles with core fields 0, then HALTED if stop_pend, else FETCH.
- HALTED: on start, clear err and stop_pend, pc<=start_pc, go to FETCH. icount is not cleared.
- stop handling:
  - stop_pend is set by stop in any busy state, or together with start.
  - A fetch in flight always completes. If that fetch returns an ALU op, the op is issued before halting.
- Latency and throughput:
  - With zero-wait ack: start at cycle 0, imem_req at cycle 1, issue at cycle 2.
  - Steady-state throughput is one issue per (2+ISSUE_GAP) cycles.
- Outside ISSUE, opcode/re/n/flag are all 0, so the core never sees a repeated or stale instruction.

Optional Feature:
- HALL98_SEQ_JMP_EN defined:
  - op 0x4B = JMP: on ack, pc<=n[PC_W-1:0], stay in FETCH (or go to HALTED if stop_pend).
  - No issue; icount unchanged.
  - A JMP to its own address is legal and loops until stop.
- Undefined: 0x4B is illegal; err=1 and go to HALTED.

Test Plan:
- Program mov(re=1,n=5), add(re=1,n=1), HALT at 0..2, ack zero-wait, start_pc=0 -> issue at cycles 2 and 4 with opcode 0x45 then 0x46; halted at cycle 6; pc=2; icount=2; err=0.
- imem_ack delayed 3 cycles per fetch -> imem_addr stable while req high; issue spacing 5 cycles; no spurious issue.
- Word 0x12000000 at address 4 -> err=1, halted=1, pc=4, no issue for that word; next start clears err.
- stop pulsed while FETCH awaits ack of an ALU op -> exactly one further issue, then halted.
- start_pc=0xFFFF with PC_W=16, NOP then ALU op at 0x0000 -> pc wraps to 0; op at address 0 issued.
- irst_n low during ISSUE -> issue, opcode and imem_req go 0 immediately; state IDLE; start ignored until irst_n high.
- (JMP_EN) JMP n=0x10 at address 0, HALT at 0x10 -> halted with pc=0x10, icount=0.
